// File: rtl/keypad_alu_sequencer.sv
// Keypad-loaded register file feeding a small ALU with a start/busy/done handshake.
// Operations read two registers, optionally write back, and report carry/zero/overflow.
module keypad_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic [AW-1:0]     key_addr,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [AW-1:0]     addr_a,
  input  logic [AW-1:0]     addr_b,
  input  logic [AW-1:0]     addr_d,
  input  logic              wb_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              overflow,
  output logic              key_drop
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic [DATA_W-1:0]     rf_r [NREGS];
  logic [DATA_W-1:0]     a_r, b_r;
  logic [2:0]            op_r;
  logic [AW-1:0]         addr_d_r;
  logic                  wb_en_r;
  logic [2*DATA_W-1:0]   mul_acc_r, mul_mcand_r, mul_sum_s;
  logic [DATA_W-1:0]     mul_mplier_r;
  logic [CW-1:0]         cnt_r;
  logic                  busy_r, done_r, carry_r, zero_r, overflow_r, key_drop_r;
  logic [DATA_W-1:0]     result_r;
  logic                  mul_last_s, finish_s, wb_fire_s, accept_s;
  logic [DATA_W:0]       ext_s;
  logic [DATA_W-1:0]     alu_res_s;
  logic                  alu_carry_s, alu_ovf_s, alu_zero_s;

  assign accept_s   = (state_r == S_IDLE) && start;
  assign mul_last_s = (state_r == S_MUL) && (cnt_r == CW'(DATA_W - 1));
  assign finish_s   = (state_r == S_EXEC) || mul_last_s;
  assign wb_fire_s  = finish_s && wb_en_r;
  assign mul_sum_s  = mul_acc_r + (mul_mplier_r[0] ? mul_mcand_r : {(2*DATA_W){1'b0}});

  // Next-state selection for the operation sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_next_s = (op == 3'b111) ? S_MUL : S_EXEC;
        else       state_next_s = S_IDLE;
      end
      S_EXEC: state_next_s = S_DONE;
      S_MUL: begin
        if (mul_last_s) state_next_s = S_DONE;
        else            state_next_s = S_MUL;
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // ALU result and flags for the finishing cycle of an operation
  always_comb begin
    ext_s       = {(DATA_W+1){1'b0}};
    alu_res_s   = {DATA_W{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (op_r)
      3'b000: begin
        ext_s       = {1'b0, a_r} + {1'b0, b_r};
        alu_res_s   = ext_s[DATA_W-1:0];
        alu_carry_s = ext_s[DATA_W];
        alu_ovf_s   = (a_r[DATA_W-1] == b_r[DATA_W-1]) && (alu_res_s[DATA_W-1] != a_r[DATA_W-1]);
      end
      3'b001: begin
        // bit DATA_W of the extended difference is the borrow
        ext_s       = {1'b0, a_r} - {1'b0, b_r};
        alu_res_s   = ext_s[DATA_W-1:0];
        alu_carry_s = ext_s[DATA_W];
        alu_ovf_s   = (a_r[DATA_W-1] != b_r[DATA_W-1]) && (alu_res_s[DATA_W-1] != a_r[DATA_W-1]);
      end
      3'b010: alu_res_s = a_r & b_r;
      3'b011: alu_res_s = a_r | b_r;
      3'b100: alu_res_s = a_r ^ b_r;
      3'b101: begin
        alu_res_s   = {a_r[DATA_W-2:0], 1'b0};
        alu_carry_s = a_r[DATA_W-1];
      end
      3'b110: begin
        alu_res_s   = {1'b0, a_r[DATA_W-1:1]};
        alu_carry_s = a_r[0];
      end
      3'b111: begin
        alu_res_s   = mul_sum_s[DATA_W-1:0];
        alu_carry_s = |mul_sum_s[2*DATA_W-1:DATA_W];
      end
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
    alu_zero_s = (alu_res_s == {DATA_W{1'b0}});
  end

  // State register and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != S_IDLE);
      done_r  <= (state_next_s == S_DONE);
    end
  end

  // Operand capture on acceptance and shift-add multiply iterations
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      op_r         <= 3'b000;
      addr_d_r     <= {AW{1'b0}};
      wb_en_r      <= 1'b0;
      mul_acc_r    <= {(2*DATA_W){1'b0}};
      mul_mcand_r  <= {(2*DATA_W){1'b0}};
      mul_mplier_r <= {DATA_W{1'b0}};
      cnt_r        <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r          <= rf_r[addr_a];
      b_r          <= rf_r[addr_b];
      op_r         <= op;
      addr_d_r     <= addr_d;
      wb_en_r      <= wb_en;
      mul_acc_r    <= {(2*DATA_W){1'b0}};
      mul_mcand_r  <= {{DATA_W{1'b0}}, rf_r[addr_a]};
      mul_mplier_r <= rf_r[addr_b];
      cnt_r        <= {CW{1'b0}};
    end else if (state_r == S_MUL) begin
      mul_acc_r    <= mul_sum_s;
      mul_mcand_r  <= {mul_mcand_r[2*DATA_W-2:0], 1'b0};
      mul_mplier_r <= {1'b0, mul_mplier_r[DATA_W-1:1]};
      cnt_r        <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Result/flag hold registers and key-drop pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r   <= {DATA_W{1'b0}};
      carry_r    <= 1'b0;
      zero_r     <= 1'b0;
      overflow_r <= 1'b0;
      key_drop_r <= 1'b0;
    end else begin
      key_drop_r <= wb_fire_s && key_valid && (key_addr == addr_d_r);
      if (finish_s) begin
        result_r   <= alu_res_s;
        carry_r    <= alu_carry_s;
        zero_r     <= alu_zero_s;
        overflow_r <= alu_ovf_s;
      end
    end
  end

  // Register file: writeback takes priority over a key write to the same register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_fire_s && (addr_d_r == AW'(i)))
          rf_r[i] <= alu_res_s;
        else if (key_valid && (key_addr == AW'(i)))
          rf_r[i] <= DATA_W'(key_code);
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign carry    = carry_r;
  assign zero     = zero_r;
  assign overflow = overflow_r;
  assign key_drop = key_drop_r;

endmodule

// File: doc/keypad_alu_sequencer.md
Name: keypad_alu_sequencer

Overview:
- Parametrised successor to the keypad/register-bank/ALU datapath of the seven-segment calculator top.
- Holds an NREGS x DATA_W register file, loaded from 4-bit keypad codes.
- Executes operations through a start/busy/done handshake, with optional writeback to a destination register.
- Adds what the previous datapath lacks: generic width and depth, a 3-bit opcode set including a multi-cycle shift-add multiply, and carry, zero and overflow flags.

Parameters:
- DATA_W, 8, datapath and register width (must be >= 4).
- NREGS, 4, number of registers (power of 2, >= 2).
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: write key_code into register key_addr.
- key_code  in  4  keypad hex code.
- key_addr  in  AW  destination register for the key write.
- start  in  1  request an operation; accepted only in IDLE.
- op  in  3  opcode.
- addr_a  in  AW  source register A.
- addr_b  in  AW  source register B.
- addr_d  in  AW  writeback destination.
- wb_en  in  1  1 = write the result to addr_d.
- busy  out  1  high from the cycle after acceptance until DONE inclusive.
- done  out  1  one-cycle pulse when the result and flags are valid.
- result  out  DATA_W  last result; held until the next DONE.
- carry  out  1  carry flag, held like result.
- zero  out  1  zero flag, held like result.
- overflow  out  1  signed-overflow flag, held like result.
- key_drop  out  1  one-cycle pulse when a key write is lost to a writeback conflict.

Behaviour:
- Reset: all registers 0; FSM to IDLE; busy, done, result, carry, zero, overflow, key_drop all 0.
- Reset mid-operation aborts: no writeback, no done pulse.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE: start=1 at cycle T latches rf[addr_a], rf[addr_b], op, addr_d and wb_en.
  - The register file is read-before-write: a key write in cycle T to a source register is not seen by that operation.
  - Next state is MUL if op=111, else EXEC.
- EXEC (T+1): compute the result, register result and flags, perform writeback if wb_en, then go to DONE.
- MUL (T+1 .. T+DATA_W): one shift-add iteration per cycle, 2*DATA_W-bit product.
  - On the last iteration, register the low DATA_W bits and flags, perform writeback if wb_en, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency, start to done: 2 cycles for ops 000-110; DATA_W+1 cycles for MUL.
- A new start is accepted in the cycle after DONE.
- start while not IDLE is ignored; there is no queue.
- Opcodes; all arithmetic is unsigned, width DATA_W, wrap-around:
  - 000 ADD: carry = carry-out; overflow = signed overflow.
  - 001 SUB A-B: carry = borrow (A<B); overflow = signed overflow.
  - 010 AND, 011 OR, 100 XOR: carry=0, overflow=0.
  - 101 SHL by 1: carry = old MSB, overflow=0.
  - 110 SHR logical by 1: carry = old LSB, overflow=0.
  - 111 MUL: result = low half; carry = 1 if high half != 0; overflow=0.
- zero = (result == 0) for every op.
- Key write: rf[key_addr] <= {zeros, key_code} on key_valid, in any FSM state.
- If a writeback and a key write occur in the same cycle:
  - Same address: writeback wins, key write dropped, key_drop=1 for that cycle.
  - Different addresses: both writes happen.
- addr_a = addr_b is legal; addr_d may equal a source register.

Test Plan (DATA_W=8, NREGS=4):
- Reset; key writes 0x9→r0, 0x7→r1; start ADD a=0 b=1 d=2 wb_en=1 -> done at start+2, result=0x10, zero=0, carry=0; a later SUB a=2 b=2 gives result 0, zero=1.
- Load r0=0x0F, r1=0x0F; MUL -> done exactly 9 cycles after start, result=0xE1, carry=0. Then MUL r2(0xE1) x r0 -> result=0x2F, carry=1.
- SUB r1(0x7) - r0(0x9) -> result=0xFE, carry=1, overflow=0. ADD on registers loaded by ADD chaining to 0x40+0x40 -> result=0x80, overflow=1.
- During MUL, pulse start with a different op -> ignored; busy stays 1; only one done pulse occurs.
- Key write to addr 2 in the same cycle as a writeback to r2 -> r2 holds the ALU result, key_drop=1. Key write to r3 in the same cycle -> written, key_drop=0.
- Assert reset at start+4 of a MUL with wb_en=1 -> no done pulse; destination register=0; all outputs 0 on the next cycle.
